// File: rtl/rda_seq_controller.sv
// rda_seq_controller
//   Sequential recursive-doubling adder. An accepted operand set is turned into
//   a per-bit carry-status vector (kill/propagate/generate). STEPS doubling
//   steps, one per cycle, resolve that vector. The sum is then presented until
//   the consumer takes it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   A, B, Cin           : operands; Cin 2'b00 = kill, 2'b11 = generate, others illegal
//   out_valid/out_ready : result handshake (valid only in DONE)
//   Sum, Cout, cin_err  : result (N+1 bits, Sum[N] = Cout), illegal-Cin flag
//   busy                : high whenever the controller is not in IDLE
module rda_seq_controller #(
  parameter int N     = 64,
  parameter int STEPS = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [1:0]   Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   Sum,
  output logic         Cout,
  output logic         cin_err,
  output logic         busy
);

  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
  typedef enum logic [1:0] {CS_KILL = 2'b00, CS_PROP = 2'b01, CS_GEN = 2'b11} cs_t;

  state_t            state;
  logic [SW-1:0]     s;
  logic [N-1:0][1:0] x;
  logic [N-1:0][1:0] x_init;
  logic [N-1:0][1:0] x_nxt;
  logic [N-1:0]      a_q;
  logic [N-1:0]      b_q;
  logic              cin_bad;
  logic [N-1:0]      sum_nxt;
  logic              cout_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // x[j] holds the carry status entering bit j, so x[0] is the carry-in.
  always_comb begin
    x_init    = '0;
    x_init[0] = (Cin == 2'b11) ? CS_GEN : CS_KILL;
    for (int unsigned j = 1; j < N; j++) begin
      if (A[j-1] & B[j-1])
        x_init[j] = CS_GEN;
      else if (A[j-1] | B[j-1])
        x_init[j] = CS_PROP;
      else
        x_init[j] = CS_KILL;
    end
  end

  // One doubling step at distance 2^s.
  always_comb begin
    x_nxt = x;
    for (int unsigned k = 0; k < STEPS; k++) begin
      if (s == SW'(k)) begin
        for (int unsigned j = 0; j < N; j++) begin
          if ((j >= (32'd1 << k)) && (x[j] == CS_PROP))
            x_nxt[j] = x[j - (32'd1 << k)];
        end
      end
    end
  end

  // The result is registered on the edge that applies the final step, so it is
  // formed from the post-step vector rather than the stored one.
  always_comb begin
    sum_nxt = '0;
    for (int unsigned j = 0; j < N; j++)
      sum_nxt[j] = a_q[j] ^ b_q[j] ^ (x_nxt[j] == CS_GEN);
    cout_nxt = (a_q[N-1] & b_q[N-1]) |
               ((a_q[N-1] ^ b_q[N-1]) & (x_nxt[N-1] == CS_GEN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s       <= '0;
      x       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_bad <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      cin_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            x       <= x_init;
            cin_bad <= (Cin == 2'b01) || (Cin == 2'b10);
            s       <= '0;
            state   <= STEP;
          end
        end
        STEP: begin
          x <= x_nxt;
          if (s == SW'(STEPS - 1)) begin
            Sum     <= {cout_nxt, sum_nxt};
            Cout    <= cout_nxt;
            cin_err <= cin_bad;
            s       <= '0;
            state   <= DONE;
          end else begin
            s <= s + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            Sum     <= '0;
            Cout    <= 1'b0;
            cin_err <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
